fft16_frame_loader: RTL and testbench

Input stage of the 16-point FFT datapath. Accepts a stream of N-bit real samples over a valid/ready handshake and stores each group of 16 consecutive samples in bit-reversed order. It presents the completed group as one flat frame to the first butterfly stage, which feeds the three-operand adder stage. Two ping-pong banks let the next frame fill while the current frame is consumed.

---
 rtl/fft16_pkg.sv | 11 +
 rtl/fft16_frame_bank.sv | 34 +++
 rtl/fft16_frame_loader.sv | 97 +++++++++
 tb/tb_fft16_frame_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants and index helpers for the 16-point FFT datapath.
package fft16_pkg;

    localparam int unsigned POINTS      = 16;
    localparam int unsigned LOG2_POINTS = 4;

    function automatic logic [LOG2_POINTS-1:0] bitrev4(input logic [LOG2_POINTS-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry sample bank: single write port, whole contents read out flat.
module fft16_frame_bank
    import fft16_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_we,
    input  logic [LOG2_POINTS-1:0] i_addr,
    input  logic [N-1:0]           i_data,
    output logic [POINTS*N-1:0]    o_frame
);

    logic [N-1:0] mem_q [POINTS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < POINTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we) begin
            mem_q[i_addr] <= i_data;
        end
    end

    always_comb begin
        o_frame = '0;
        for (int unsigned i = 0; i < POINTS; i++) begin
            o_frame[i*N +: N] = mem_q[i];
        end
    end

endmodule

// File: rtl/fft16_frame_loader.sv
// FFT input stage: streams samples into ping-pong banks in bit-reversed order
// and presents each completed bank as one flat frame.
module fft16_frame_loader
    import fft16_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [N-1:0]        i_data,
    output logic                o_ready,
    output logic                o_frame_valid,
    input  logic                i_frame_ack,
    output logic [POINTS*N-1:0] o_frame,
    output logic                o_overflow
);

    logic [1:0]             bank_full_q, bank_full_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [LOG2_POINTS-1:0] wr_cnt_q, wr_cnt_d;
    logic                   overflow_q, overflow_d;

    logic                   accept, rel, last_sample;
    logic [1:0]             bank_we;
    logic [LOG2_POINTS-1:0] wr_addr;
    logic [POINTS*N-1:0]    bank_frame [2];

    assign o_ready       = !bank_full_q[wr_bank_q];
    assign o_frame_valid = bank_full_q[rd_bank_q];
    assign o_frame       = bank_frame[rd_bank_q];
    assign o_overflow    = overflow_q;

    always_comb begin
        accept      = i_valid && o_ready;
        rel         = i_frame_ack && o_frame_valid;
        last_sample = accept && (wr_cnt_q == LOG2_POINTS'(POINTS - 1));
        wr_addr     = bitrev4(wr_cnt_q);

        bank_we     = '0;
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        overflow_d  = overflow_q | (i_valid & ~o_ready);

        if (accept) begin
            bank_we[wr_bank_q] = 1'b1;
            wr_cnt_d           = wr_cnt_q + LOG2_POINTS'(1);
        end
        // Set and clear can share an edge: the write bank is never the full read bank.
        if (last_sample) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (rel) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    fft16_frame_bank #(.N(N)) u_bank0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (bank_we[0]),
        .i_addr  (wr_addr),
        .i_data  (i_data),
        .o_frame (bank_frame[0])
    );

    fft16_frame_bank #(.N(N)) u_bank1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (bank_we[1]),
        .i_addr  (wr_addr),
        .i_data  (i_data),
        .o_frame (bank_frame[1])
    );

endmodule

// File: tb/tb_fft16_frame_loader.sv
// Directed self-checking bench for fft16_frame_loader.
module tb_fft16_frame_loader;

    localparam int unsigned N  = 16;
    localparam int unsigned FW = 16 * N;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [N-1:0]  i_data = '0;
    logic          o_ready;
    logic          o_frame_valid;
    logic          i_frame_ack = 1'b0;
    logic [FW-1:0] o_frame;
    logic          o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fft16_frame_loader #(.N(N)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_frame_valid (o_frame_valid),
        .i_frame_ack   (i_frame_ack),
        .o_frame       (o_frame),
        .o_overflow    (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned rev4(input int unsigned k);
        int unsigned r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r |= (1 << (3 - b));
        end
        return r;
    endfunction

    // Sample k of a frame lands in slot rev4(k), so slot j holds sample rev4(j).
    function automatic logic [FW-1:0] exp_frame(input int unsigned base);
        logic [FW-1:0] r = '0;
        for (int j = 0; j < 16; j++) begin
            r[j*N +: N] = N'(base + rev4(j));
        end
        return r;
    endfunction

    function automatic logic [N-1:0] slot(input logic [FW-1:0] f, input int j);
        return f[j*N +: N];
    endfunction

    task automatic do_reset();
        i_valid     = 1'b0;
        i_frame_ack = 1'b0;
        i_rst       = 1'b1;
        #3;
        check_eq("rst_ready", FW'(o_ready), FW'(1));
        check_eq("rst_fvalid", FW'(o_frame_valid), FW'(0));
        check_eq("rst_frame", o_frame, '0);
        check_eq("rst_ovf", FW'(o_overflow), FW'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic send(input int unsigned d);
        i_valid = 1'b1;
        i_data  = N'(d);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        int unsigned nfr;

        @(negedge i_clk);

        // Test 1: one frame of 0..15
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check_eq("t1_fvalid_before_last", FW'(o_frame_valid), FW'(0));
            send(k);
        end
        check_eq("t1_fvalid", FW'(o_frame_valid), FW'(1));
        check_eq("t1_slot0", FW'(slot(o_frame, 0)), FW'(16'h0000));
        check_eq("t1_slot1", FW'(slot(o_frame, 1)), FW'(16'h0008));
        check_eq("t1_slot8", FW'(slot(o_frame, 8)), FW'(16'h0001));
        check_eq("t1_slot15", FW'(slot(o_frame, 15)), FW'(16'h000F));
        check_eq("t1_frame", o_frame, exp_frame(0));
        i_frame_ack = 1'b1;
        @(negedge i_clk);
        i_frame_ack = 1'b0;
        check_eq("t1_fvalid_after_ack", FW'(o_frame_valid), FW'(0));

        // Test 2: 48 continuous samples, each frame acked the cycle after it appears
        do_reset();
        cnt = 0;
        nfr = 0;
        for (int cyc = 0; cyc < 100 && nfr < 3; cyc++) begin
            if (cnt < 48) begin
                check_eq("t2_ready", FW'(o_ready), FW'(1));
                i_valid = 1'b1;
                i_data  = N'(cnt);
                cnt++;
            end else begin
                i_valid = 1'b0;
            end
            if (o_frame_valid) begin
                check_eq($sformatf("t2_frame%0d", nfr), o_frame, exp_frame(16 * nfr));
                if (nfr == 2) check_eq("t2_f2_slot1", FW'(slot(o_frame, 1)), FW'(16'h0028));
                i_frame_ack = 1'b1;
                nfr++;
            end else begin
                i_frame_ack = 1'b0;
            end
            @(negedge i_clk);
        end
        i_valid     = 1'b0;
        i_frame_ack = 1'b0;
        check_eq("t2_nframes", FW'(nfr), FW'(3));
        check_eq("t2_fvalid_end", FW'(o_frame_valid), FW'(0));
        check_eq("t2_ovf", FW'(o_overflow), FW'(0));

        // Test 3: no ack, both banks fill, overflow, then one release
        do_reset();
        for (int k = 0; k < 32; k++) begin
            if (k == 31) check_eq("t3_ready_before_31", FW'(o_ready), FW'(1));
            send(k);
        end
        check_eq("t3_ready_low", FW'(o_ready), FW'(0));
        check_eq("t3_ovf_clear", FW'(o_overflow), FW'(0));
        check_eq("t3_fvalid", FW'(o_frame_valid), FW'(1));
        i_valid = 1'b1;
        i_data  = N'(32);
        @(negedge i_clk);
        check_eq("t3_ovf_set", FW'(o_overflow), FW'(1));
        check_eq("t3_ready_still_low", FW'(o_ready), FW'(0));
        @(negedge i_clk);
        check_eq("t3_frame_hold", o_frame, exp_frame(0));
        i_frame_ack = 1'b1;
        @(negedge i_clk);
        i_frame_ack = 1'b0;
        check_eq("t3_ready_after_ack", FW'(o_ready), FW'(1));
        check_eq("t3_fvalid_after_ack", FW'(o_frame_valid), FW'(1));
        check_eq("t3_frame1", o_frame, exp_frame(16));
        for (int k = 32; k < 40; k++) send(k);
        check_eq("t3_ovf_sticky", FW'(o_overflow), FW'(1));
        check_eq("t3_frame1_hold", o_frame, exp_frame(16));

        // Test 4: last sample of frame 1 and ack of frame 0 on the same edge
        do_reset();
        for (int k = 0; k < 31; k++) send(k);
        check_eq("t4_ready", FW'(o_ready), FW'(1));
        check_eq("t4_frame0", o_frame, exp_frame(0));
        i_frame_ack = 1'b1;
        send(31);
        i_frame_ack = 1'b0;
        check_eq("t4_fvalid", FW'(o_frame_valid), FW'(1));
        check_eq("t4_frame1", o_frame, exp_frame(16));
        check_eq("t4_ready_after", FW'(o_ready), FW'(1));
        i_frame_ack = 1'b1;
        send(32);
        i_frame_ack = 1'b0;
        for (int k = 33; k < 48; k++) send(k);
        check_eq("t4_frame2", o_frame, exp_frame(32));

        // Test 5: reset mid-frame discards the partial frame
        do_reset();
        for (int k = 0; k < 7; k++) send(32'h0A0 + k);
        do_reset();
        for (int k = 0; k < 16; k++) send(32'h100 + k);
        check_eq("t5_fvalid", FW'(o_frame_valid), FW'(1));
        check_eq("t5_slot1", FW'(slot(o_frame, 1)), FW'(16'h0108));
        check_eq("t5_frame", o_frame, exp_frame(32'h100));

        // Test 6: acks with nothing presented are ignored
        do_reset();
        i_frame_ack = 1'b1;
        repeat (3) @(negedge i_clk);
        i_frame_ack = 1'b0;
        check_eq("t6_fvalid", FW'(o_frame_valid), FW'(0));
        check_eq("t6_ready", FW'(o_ready), FW'(1));
        check_eq("t6_frame_zero", o_frame, '0);
        for (int k = 0; k < 16; k++) send(32'h200 + k);
        check_eq("t6_fvalid_after", FW'(o_frame_valid), FW'(1));
        check_eq("t6_frame", o_frame, exp_frame(32'h200));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
